// File: rtl/prd_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : prd_bus_master
// Function : PRD command-board bus master. Arbitrates two requesters and runs
//            each grant as a timed setup/strobe/hold bus cycle.
//            Define PRD_BUS_ARB_RR_EN for round-robin arbitration
//            (fixed priority, requester 0 first, otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module prd_bus_master #(
  parameter logic [3:0]  CS         = 4'b1011,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        iRes,
  input  logic        iBl,
  input  logic        iReq0,
  input  logic        iReq1,
  input  logic        iWr0,
  input  logic        iWr1,
  input  logic [1:0]  iA0,
  input  logic [1:0]  iA1,
  input  logic [15:0] iD0,
  input  logic [15:0] iD1,
  output logic        oAck0,
  output logic        oAck1,
  output logic [15:0] oQ,
  output logic [3:0]  oCS,
  output logic [1:0]  oA,
  output logic        oRd,
  output logic        oWr,
  output logic [15:0] oD,
  output logic        oDOe,
  input  logic [15:0] iD
);

  localparam logic [3:0] c_SETUP_N  = (SETUP_CYC  == 0) ? 4'd1 : 4'(SETUP_CYC);
  localparam logic [3:0] c_STROBE_N = (STROBE_CYC == 0) ? 4'd1 : 4'(STROBE_CYC);
  localparam logic [3:0] c_HOLD_N   = (HOLD_CYC   == 0) ? 4'd1 : 4'(HOLD_CYC);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETUP  = 2'd1;
  localparam logic [1:0] c_STROBE = 2'd2;
  localparam logic [1:0] c_HOLD   = 2'd3;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_grant;
  logic        r_wr;

  logic        w_any;
  logic        w_pick;
  logic        w_wr;
  logic [1:0]  w_addr;
  logic [15:0] w_data;

  assign w_any = iReq0 | iReq1;

`ifdef PRD_BUS_ARB_RR_EN
  logic r_rrLast;
  // On a tie the requester that was not served last wins.
  assign w_pick = (iReq0 & iReq1) ? ~r_rrLast : iReq1;
`else
  assign w_pick = ~iReq0;
`endif

  assign w_wr   = w_pick ? iWr1 : iWr0;
  assign w_addr = w_pick ? iA1  : iA0;
  assign w_data = w_pick ? iD1  : iD0;

  always_ff @(posedge clk or posedge iRes) begin
    if (iRes) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
      r_grant <= 1'b0;
      r_wr    <= 1'b0;
      oCS     <= ~CS;
      oA      <= 2'd0;
      oRd     <= 1'b1;
      oWr     <= 1'b1;
      oD      <= 16'd0;
      oDOe    <= 1'b0;
      oAck0   <= 1'b0;
      oAck1   <= 1'b0;
      oQ      <= 16'd0;
`ifdef PRD_BUS_ARB_RR_EN
      r_rrLast <= 1'b1;
`endif
    end else begin
      oAck0 <= 1'b0;
      oAck1 <= 1'b0;
      case (r_state)
        c_IDLE: begin
          // The ack cycle never grants: a requester still holding req on
          // its ack clock must not be served twice.
          if (iBl && !oAck0 && !oAck1 && w_any) begin
            r_grant <= w_pick;
            r_wr    <= w_wr;
            oCS     <= CS;
            oA      <= w_addr;
            if (w_wr) begin
              oD   <= w_data;
              oDOe <= 1'b1;
            end
            r_cnt   <= c_SETUP_N - 4'd1;
            r_state <= c_SETUP;
`ifdef PRD_BUS_ARB_RR_EN
            r_rrLast <= w_pick;
`endif
          end
        end
        c_SETUP: begin
          if (r_cnt == 4'd0) begin
            oRd     <= r_wr;
            oWr     <= ~r_wr;
            r_cnt   <= c_STROBE_N - 4'd1;
            r_state <= c_STROBE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_STROBE: begin
          if (r_cnt == 4'd0) begin
            oRd <= 1'b1;
            oWr <= 1'b1;
            if (!r_wr) begin
              oQ <= iD;
            end
            r_cnt   <= c_HOLD_N - 4'd1;
            r_state <= c_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          if (r_cnt == 4'd0) begin
            oCS     <= ~CS;
            oDOe    <= 1'b0;
            oAck0   <= ~r_grant;
            oAck1   <= r_grant;
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prd_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_prd_bus_master
// Function : Self-checking bench for prd_bus_master (default and swept timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prd_bus_master;

  localparam logic [3:0] CSV = 4'b1011;
  localparam logic [3:0] NCS = 4'b0100;
  localparam int S   = 1;
  localparam int ST  = 2;
  localparam int H   = 1;
  localparam int TOT = S + ST + H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        iRes, iBl, iReq0, iReq1, iWr0, iWr1;
  logic [1:0]  iA0, iA1;
  logic [15:0] iD0, iD1, busD;
  logic        oAck0, oAck1, oRd, oWr, oDOe;
  logic [15:0] oQ, oD;
  logic [3:0]  oCS;
  logic [1:0]  oA;

  logic        sReq;
  logic        sAck0, sAck1, sRd, sWr, sDOe;
  logic [15:0] sQ, sD;
  logic [3:0]  sCS;
  logic [1:0]  sA;

  int checks = 0;
  int errors = 0;

  prd_bus_master dut (
    .clk(clk), .iRes(iRes), .iBl(iBl),
    .iReq0(iReq0), .iReq1(iReq1), .iWr0(iWr0), .iWr1(iWr1),
    .iA0(iA0), .iA1(iA1), .iD0(iD0), .iD1(iD1),
    .oAck0(oAck0), .oAck1(oAck1), .oQ(oQ), .oCS(oCS), .oA(oA),
    .oRd(oRd), .oWr(oWr), .oD(oD), .oDOe(oDOe), .iD(busD)
  );

  prd_bus_master #(.CS(4'b1011), .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) sweep (
    .clk(clk), .iRes(iRes), .iBl(1'b1),
    .iReq0(sReq), .iReq1(1'b0), .iWr0(1'b0), .iWr1(1'b0),
    .iA0(2'd1), .iA1(2'd0), .iD0(16'd0), .iD1(16'd0),
    .oAck0(sAck0), .oAck1(sAck1), .oQ(sQ), .oCS(sCS), .oA(sA),
    .oRd(sRd), .oWr(sWr), .oD(sD), .oDOe(sDOe), .iD(busD)
  );

`ifdef PRD_BUS_ARB_RR_EN
  bit rrLast = 1'b1;
`endif

  // Reference arbiter: who should win given the pending requests.
  function automatic bit predict(input bit r0, input bit r1);
    bit w;
`ifdef PRD_BUS_ARB_RR_EN
    w = (r0 && r1) ? !rrLast : r1;
    rrLast = w;
`else
    w = r0 ? 1'b0 : 1'b1;
`endif
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitGrant(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (oCS === CSV) begin
        n = i;
        break;
      end
    end
    chk("grant_seen", 32'(n > 0), 32'd1);
  endtask

  // Called on the first sample after the grant edge; returns on the ack sample.
  task automatic observeAccess(input bit wr, input logic [1:0] a, input logic [15:0] d,
                               input logic [15:0] bd, input bit expWho);
    bit inStrobe;
    for (int k = 0; k < TOT; k++) begin
      if (k > 0) @(negedge clk);
      inStrobe = (k >= S) && (k < S + ST);
      chk("cs_active", 32'(oCS), 32'(CSV));
      chk("addr", 32'(oA), 32'(a));
      chk("rd_strobe", 32'(oRd), 32'(!(inStrobe && !wr)));
      chk("wr_strobe", 32'(oWr), 32'(!(inStrobe && wr)));
      chk("doe", 32'(oDOe), 32'(wr));
      if (wr) chk("dout", 32'(oD), 32'(d));
      chk("no_early_ack", 32'({oAck0, oAck1}), 32'd0);
    end
    @(negedge clk);
    chk("ack0", 32'(oAck0), 32'(!expWho));
    chk("ack1", 32'(oAck1), 32'(expWho));
    chk("cs_idle", 32'(oCS), 32'(NCS));
    chk("doe_idle", 32'(oDOe), 32'd0);
    if (!wr) chk("rdata", 32'(oQ), 32'(bd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit who, sel0, sel1, wrA, wrB;
    logic [1:0] aA, aB;
    logic [15:0] dA, dB, r;

    iRes = 1'b1; iBl = 1'b1; iReq0 = 1'b0; iReq1 = 1'b0; iWr0 = 1'b0; iWr1 = 1'b0;
    iA0 = 2'd0; iA1 = 2'd0; iD0 = 16'd0; iD1 = 16'd0; busD = 16'd0; sReq = 1'b0;
    @(negedge clk);
    chk("rst_cs", 32'(oCS), 32'(NCS));
    chk("rst_a", 32'(oA), 32'd0);
    chk("rst_rd_wr", 32'({oRd, oWr}), 32'd3);
    chk("rst_d", 32'(oD), 32'd0);
    chk("rst_doe", 32'(oDOe), 32'd0);
    chk("rst_ack", 32'({oAck0, oAck1}), 32'd0);
    chk("rst_q", 32'(oQ), 32'd0);
    chk("rst_sweep_cs", 32'(sCS), 32'(NCS));
    @(negedge clk);
    iRes = 1'b0;

    // Directed read on requester 0
    iReq0 = 1'b1; iWr0 = 1'b0; iA0 = 2'b11; busD = 16'hA44A;
    waitGrant(n);
    chk("read_latency", 32'(n), 32'd1);
    observeAccess(1'b0, 2'b11, 16'h0, 16'hA44A, predict(1'b1, 1'b0));
    iReq0 = 1'b0;

    // Directed write on requester 1
    iReq1 = 1'b1; iWr1 = 1'b1; iA1 = 2'b10; iD1 = 16'h4321;
    waitGrant(n);
    observeAccess(1'b1, 2'b10, 16'h4321, busD, predict(1'b0, 1'b1));
    iReq1 = 1'b0;

    // Both requesters held across four accesses
    iReq0 = 1'b1; iWr0 = 1'b0; iA0 = 2'b01; iD0 = 16'h1111;
    iReq1 = 1'b1; iWr1 = 1'b1; iA1 = 2'b10; iD1 = 16'h2222;
    busD = 16'h5A5A;
    waitGrant(n);
    for (int i = 0; i < 4; i++) begin
      who = predict(1'b1, 1'b1);
      if (who) observeAccess(1'b1, 2'b10, 16'h2222, busD, 1'b1);
      else     observeAccess(1'b0, 2'b01, 16'h1111, busD, 1'b0);
      if (i < 3) begin
        @(negedge clk);
        chk("gap_idle", 32'({oCS, oAck0, oAck1}), 32'({NCS, 2'b00}));
        @(negedge clk);
        chk("gap_regrant", 32'(oCS), 32'(CSV));
      end
    end
    iReq0 = 1'b0; iReq1 = 1'b0;

    // Reset during the first strobe clock
    iReq0 = 1'b1; iWr0 = 1'b0; iA0 = 2'b01; busD = 16'h0F0F;
    waitGrant(n);
    @(negedge clk);
    chk("pre_reset_rd_low", 32'(oRd), 32'd0);
    #1 iRes = 1'b1;
    #1;
    chk("async_rst_rd", 32'(oRd), 32'd1);
    chk("async_rst_cs", 32'(oCS), 32'(NCS));
    chk("async_rst_doe", 32'(oDOe), 32'd0);
    @(negedge clk);
    chk("rst_no_ack", 32'({oAck0, oAck1}), 32'd0);
    chk("rst_q_cleared", 32'(oQ), 32'd0);
`ifdef PRD_BUS_ARB_RR_EN
    rrLast = 1'b1;
`endif
    iRes = 1'b0;
    waitGrant(n);
    chk("post_reset_latency", 32'(n), 32'd1);
    observeAccess(1'b0, 2'b01, 16'h0, 16'h0F0F, predict(1'b1, 1'b0));
    iReq0 = 1'b0;

    // Block input
    iBl = 1'b0; iReq0 = 1'b1; iWr0 = 1'b1; iA0 = 2'b10; iD0 = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("blocked_cs", 32'(oCS), 32'(NCS));
    end
    iBl = 1'b1;
    @(negedge clk);
    chk("unblock_grant", 32'(oCS), 32'(CSV));
    iBl = 1'b0;
    observeAccess(1'b1, 2'b10, 16'hBEEF, busD, predict(1'b1, 1'b0));
    iReq0 = 1'b0; iBl = 1'b1;

    // Randomized accesses, some with the request dropped mid-access
    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n = $urandom_range(0, 2);
      sel0 = (n != 1); sel1 = (n != 0);
      wrA = 1'($urandom_range(0, 1)); wrB = 1'($urandom_range(0, 1));
      aA = 2'($urandom_range(0, 3)); aB = 2'($urandom_range(0, 3));
      dA = 16'($urandom); dB = 16'($urandom); r = 16'($urandom);
      iReq0 = sel0; iWr0 = wrA; iA0 = aA; iD0 = dA;
      iReq1 = sel1; iWr1 = wrB; iA1 = aB; iD1 = dB;
      busD = r;
      waitGrant(n);
      who = predict(sel0, sel1);
      if ($urandom_range(0, 1) == 1) begin
        iReq0 = 1'b0; iReq1 = 1'b0;
      end
      if (who) observeAccess(wrB, aB, dB, r, 1'b1);
      else     observeAccess(wrA, aA, dA, r, 1'b0);
      iReq0 = 1'b0; iReq1 = 1'b0;
    end

    // Swept timing instance: setup 3, strobe 1, hold 2
    busD = 16'hC3C3;
    sReq = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sCS === CSV) begin
        n = i;
        break;
      end
    end
    chk("sweep_grant", 32'(n), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("sweep_cs", 32'(sCS), 32'(CSV));
      chk("sweep_rd", 32'(sRd), 32'(k != 3));
      chk("sweep_no_ack", 32'(sAck0), 32'd0);
    end
    @(negedge clk);
    chk("sweep_ack", 32'(sAck0), 32'd1);
    chk("sweep_cs_idle", 32'(sCS), 32'(NCS));
    chk("sweep_rdata", 32'(sQ), 32'hC3C3);
    sReq = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
